// File: rtl/pes_gc_pkg.sv
// Shared widths, FSM state type and Hamming-distance helper for the Gray-count decoder.
package pes_gc_pkg;
    localparam int GC_WIDTH     = 8;
    localparam int RELOCK_STEPS = 2;
    localparam int DIST_W       = $clog2(GC_WIDTH + 1);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        LOCKED   = 2'd1,
        UNLOCKED = 2'd2
    } gc_state_e;

    function automatic logic [DIST_W-1:0] hamming(input logic [GC_WIDTH-1:0] a,
                                                  input logic [GC_WIDTH-1:0] b);
        logic [GC_WIDTH-1:0] x;
        logic [DIST_W-1:0]   cnt;
        x   = a ^ b;
        cnt = '0;
        for (int i = 0; i < GC_WIDTH; i++) begin
            cnt = cnt + DIST_W'(x[i]);
        end
        return cnt;
    endfunction
endpackage

// File: rtl/pes_gray2bin.sv
// Combinational Gray-to-binary decode: MSB passes through, each lower bit
// is the running XOR of all Gray bits above and including it.
module pes_gray2bin #(
    parameter int GC_WIDTH = pes_gc_pkg::GC_WIDTH
) (
    input  logic [GC_WIDTH-1:0] gray,
    output logic [GC_WIDTH-1:0] bin
);

    // Prefix XOR from the MSB downwards.
    always_comb begin
        logic acc_s;
        bin                 = '0;
        acc_s               = gray[GC_WIDTH-1];
        bin[GC_WIDTH-1]     = acc_s;
        for (int i = GC_WIDTH - 2; i >= 0; i--) begin
            acc_s  = acc_s ^ gray[i];
            bin[i] = acc_s;
        end
    end

endmodule

// File: rtl/pes_gcdecoder.sv
// Two-stage Gray-count decoder with step checking and lock tracking.
// Optional saturating error counter selected by macro PES_GC_ERRCNT_EN.
module pes_gcdecoder
    import pes_gc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [GC_WIDTH-1:0] gray_in,
    output logic [GC_WIDTH-1:0] bin_count,
    output logic                valid,
    output logic                dir,
    output logic                wrap,
    output logic                step_err,
    output logic                locked
`ifdef PES_GC_ERRCNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    logic [GC_WIDTH-1:0] g_q_r;
    logic                v1_r;
    logic [GC_WIDTH-1:0] prev_g_r;
    logic [GC_WIDTH-1:0] prev_b_r;
    logic [1:0]          good_run_r;
    gc_state_e           state_r;

    logic [GC_WIDTH-1:0] b_new_s;
    logic [GC_WIDTH-1:0] diff_s;
    logic [DIST_W-1:0]   dist_s;
    logic                good_s;
    logic                err_s;
    logic                wrap_s;

    pes_gray2bin #(.GC_WIDTH(GC_WIDTH)) u_gray2bin (
        .gray (g_q_r),
        .bin  (b_new_s)
    );

    assign dist_s = hamming(g_q_r, prev_g_r);
    assign diff_s = b_new_s - prev_b_r;

    // Classify the staged sample; INIT samples are never compared.
    always_comb begin
        good_s = 1'b0;
        err_s  = 1'b0;
        wrap_s = 1'b0;
        if (v1_r && (state_r != INIT)) begin
            good_s = (dist_s == DIST_W'(1));
            err_s  = (dist_s >  DIST_W'(1));
            wrap_s = ((prev_b_r == {GC_WIDTH{1'b1}}) && (b_new_s == {GC_WIDTH{1'b0}})) ||
                     ((prev_b_r == {GC_WIDTH{1'b0}}) && (b_new_s == {GC_WIDTH{1'b1}}));
        end else begin
            good_s = 1'b0;
            err_s  = 1'b0;
            wrap_s = 1'b0;
        end
    end

    // Stage 1: capture the raw sample and its strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q_r <= '0;
            v1_r  <= 1'b0;
        end else begin
            g_q_r <= gray_in;
            v1_r  <= enable;
        end
    end

    // Stage 2: outputs, history and lock FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_count  <= '0;
            valid      <= 1'b0;
            dir        <= 1'b0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            locked     <= 1'b0;
            prev_g_r   <= '0;
            prev_b_r   <= '0;
            good_run_r <= 2'd0;
            state_r    <= INIT;
        end else begin
            valid    <= v1_r;
            wrap     <= good_s & wrap_s;
            step_err <= err_s;
            if (v1_r) begin
                bin_count <= b_new_s;
                prev_g_r  <= g_q_r;
                prev_b_r  <= b_new_s;
                if (good_s) begin
                    dir <= (diff_s == GC_WIDTH'(1));
                end
                case (state_r)
                    INIT: begin
                        state_r    <= LOCKED;
                        locked     <= 1'b1;
                        good_run_r <= 2'd0;
                    end
                    LOCKED: begin
                        if (err_s) begin
                            state_r    <= UNLOCKED;
                            locked     <= 1'b0;
                            good_run_r <= 2'd0;
                        end
                    end
                    UNLOCKED: begin
                        if (err_s) begin
                            good_run_r <= 2'd0;
                        end else if (good_s) begin
                            if (good_run_r == 2'(RELOCK_STEPS - 1)) begin
                                state_r    <= LOCKED;
                                locked     <= 1'b1;
                                good_run_r <= 2'd0;
                            end else begin
                                good_run_r <= good_run_r + 2'd1;
                            end
                        end
                    end
                    default: begin
                        state_r    <= INIT;
                        locked     <= 1'b0;
                        good_run_r <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef PES_GC_ERRCNT_EN
    // Saturating step-error counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (err_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pes_gcdecoder.sv
// Self-checking bench for pes_gcdecoder: spec-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_pes_gcdecoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] gray_in = 8'h00;
    logic [7:0] bin_count;
    logic       valid, dir, wrap, step_err, locked;
`ifdef PES_GC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    pes_gcdecoder dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .gray_in   (gray_in),
        .bin_count (bin_count),
        .valid     (valid),
        .dir       (dir),
        .wrap      (wrap),
        .step_err  (step_err),
        .locked    (locked)
`ifdef PES_GC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_valid = 0, cnt_wrap = 0, cnt_step = 0;

    // model state
    int m_bin, m_dir, m_locked, m_err, m_first, m_prev_g, m_prev_b, m_run;
    int e_valid, e_wrap, e_step;
    int p_en, p_g;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b & 255;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 255;
    endfunction

    task automatic model_clear();
        m_bin = 0; m_dir = 0; m_locked = 0; m_err = 0; m_first = 1;
        m_prev_g = 0; m_prev_b = 0; m_run = 0;
        e_valid = 0; e_wrap = 0; e_step = 0;
        p_en = 0; p_g = 0;
    endtask

    task automatic model_step(input int en, input int g);
        int b, d;
        e_valid = 0; e_wrap = 0; e_step = 0;
        if (en != 0) begin
            b = g2b(g);
            e_valid = 1;
            m_bin = b;
            if (m_first != 0) begin
                m_first = 0;
                m_locked = 1;
            end else begin
                d = $countones(g ^ m_prev_g);
                if (d == 1) begin
                    m_dir  = (((b - m_prev_b) & 255) == 1) ? 1 : 0;
                    e_wrap = ((m_prev_b == 255 && b == 0) || (m_prev_b == 0 && b == 255)) ? 1 : 0;
                    if (m_locked == 0) begin
                        m_run++;
                        if (m_run >= 2) begin
                            m_locked = 1;
                            m_run = 0;
                        end
                    end
                end else if (d >= 2) begin
                    e_step = 1;
                    if (m_err < 255) m_err++;
                    m_locked = 0;
                    m_run = 0;
                end
            end
            m_prev_g = g;
            m_prev_b = b;
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset) model_clear();
            chk("bin_count", bin_count, m_bin);
            chk("valid", valid, e_valid);
            chk("dir", dir, m_dir);
            chk("wrap", wrap, e_wrap);
            chk("step_err", step_err, e_step);
            chk("locked", locked, m_locked);
`ifdef PES_GC_ERRCNT_EN
            chk("err_count", err_count, m_err);
`endif
            cnt_valid += int'(valid);
            cnt_wrap  += int'(wrap);
            cnt_step  += int'(step_err);
            if (reset) begin
                model_step(p_en, p_g);
                p_en = int'(enable);
                p_g  = int'(gray_in);
            end
        end
    end

    task automatic drive(input logic [7:0] g);
        @(posedge clk); #1;
        enable  = 1'b1;
        gray_in = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            enable = 1'b0;
        end
    endtask

    task automatic settle();
        idle(3);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cnt_valid = 0; cnt_wrap = 0; cnt_step = 0;
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_bin", bin_count, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Scenario 1: 300 up-counting samples through one wrap.
        do_reset();
        for (int i = 0; i < 300; i++) drive(8'(b2g(i % 256)));
        settle();
        chk("s1_valid_cnt", cnt_valid, 300);
        chk("s1_wrap_cnt", cnt_wrap, 1);
        chk("s1_step_cnt", cnt_step, 0);
        chk("s1_bin", bin_count, 43);
        chk("s1_dir", dir, 1);
        chk("s1_locked", locked, 1);

        // Scenario 2: counting down through 0 -> 255.
        do_reset();
        drive(8'h03); drive(8'h01); drive(8'h00); drive(8'h80);
        settle();
        chk("s2_valid_cnt", cnt_valid, 4);
        chk("s2_wrap_cnt", cnt_wrap, 1);
        chk("s2_dir", dir, 0);
        chk("s2_bin", bin_count, 255);

        // Scenario 3: a 2-bit jump, then relock after two good steps.
        do_reset();
        drive(8'h00); drive(8'h03);
        settle();
        chk("s3_step_cnt", cnt_step, 1);
        chk("s3_locked_lost", locked, 0);
        chk("s3_bin", bin_count, 2);
`ifdef PES_GC_ERRCNT_EN
        chk("s3_err_count", err_count, 1);
`endif
        drive(8'h02);
        settle();
        chk("s3_locked_one_good", locked, 0);
        drive(8'h06);
        settle();
        chk("s3_locked_two_good", locked, 1);
        chk("s3_bin_final", bin_count, 4);
        chk("s3_dir", dir, 1);

        // Scenario 4: repeated word is a hold.
        do_reset();
        drive(8'h05); drive(8'h05); drive(8'h05);
        settle();
        chk("s4_valid_cnt", cnt_valid, 3);
        chk("s4_step_cnt", cnt_step, 0);
        chk("s4_wrap_cnt", cnt_wrap, 0);
        chk("s4_bin", bin_count, 6);

        // Scenario 5: alternating 0x00/0xFF saturates the error counter.
        do_reset();
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 8'h00 : 8'hFF);
        settle();
        chk("s5_step_cnt", cnt_step, 299);
        chk("s5_bin", bin_count, 170);
        chk("s5_locked", locked, 0);
`ifdef PES_GC_ERRCNT_EN
        chk("s5_err_count", err_count, 255);
`endif

        // Scenario 6: reset with a sample in flight.
        do_reset();
        drive(8'h00); drive(8'h01);
        @(posedge clk); #1;
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("s6_rst_bin", bin_count, 0);
        chk("s6_rst_valid", valid, 0);
        chk("s6_rst_dir", dir, 0);
        chk("s6_rst_wrap", wrap, 0);
        chk("s6_rst_step", step_err, 0);
        chk("s6_rst_locked", locked, 0);
`ifdef PES_GC_ERRCNT_EN
        chk("s6_rst_err_count", err_count, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        cnt_valid = 0; cnt_wrap = 0; cnt_step = 0;
        drive(8'hFF);
        settle();
        chk("s6_valid_cnt", cnt_valid, 1);
        chk("s6_step_cnt", cnt_step, 0);
        chk("s6_locked", locked, 1);
        chk("s6_bin", bin_count, 170);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
